// File: rtl/word_bank.sv
// Clocked word bank: DEPTH words of BUSWIDTH bits with per-lane writes, a registered
// one-cycle read port and a sequencer that zeroes every word after reset or on request.
module word_bank #(
  parameter int BUSWIDTH  = 8,
  parameter int LANEWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int ADDRWIDTH = 4,
  parameter int RDW_MODE  = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  output logic                           ready_o,
  input  logic [ADDRWIDTH-1:0]           addr_i,
  input  logic                           WEn_i,
  input  logic [BUSWIDTH/LANEWIDTH-1:0]  lane_en_i,
  input  logic [BUSWIDTH-1:0]            data_i,
  input  logic                           REn_i,
  output logic [BUSWIDTH-1:0]            data_o,
  output logic                           valid_o
);

  localparam int LANES = BUSWIDTH / LANEWIDTH;
  localparam logic [ADDRWIDTH:0]   DEPTH_W   = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DEPTH - 1);
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE  = ADDRWIDTH'(32'd1);
  localparam logic [ADDRWIDTH-1:0] ADDR_ZERO = {ADDRWIDTH{1'b0}};
  localparam logic [BUSWIDTH-1:0]  WORD_ZERO = {BUSWIDTH{1'b0}};

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t                state_r, state_nxt_s;
  logic [ADDRWIDTH-1:0]  clr_addr_r, clr_addr_nxt_s;
  logic                  ready_r, ready_nxt_s;
  logic                  valid_r, valid_nxt_s;
  logic [BUSWIDTH-1:0]   data_r, data_nxt_s;
  logic [BUSWIDTH-1:0]   mem_r [DEPTH];

  logic                  clr_last_s;
  logic                  in_range_s;
  logic [BUSWIDTH-1:0]   rd_word_s;
  logic [BUSWIDTH-1:0]   merged_s;
  logic                  mem_we_s;
  logic [ADDRWIDTH-1:0]  mem_addr_s;
  logic [BUSWIDTH-1:0]   mem_wdata_s;

  // Replace the enabled lanes of old_word with the matching lanes of new_word.
  function automatic logic [BUSWIDTH-1:0] merge_lanes(
    input logic [BUSWIDTH-1:0] old_word,
    input logic [BUSWIDTH-1:0] new_word,
    input logic [LANES-1:0]    mask
  );
    logic [BUSWIDTH-1:0] res;
    res = old_word;
    for (int j = 0; j < LANES; j++) begin
      if (mask[j]) begin
        res[j*LANEWIDTH +: LANEWIDTH] = new_word[j*LANEWIDTH +: LANEWIDTH];
      end else begin
        res[j*LANEWIDTH +: LANEWIDTH] = old_word[j*LANEWIDTH +: LANEWIDTH];
      end
    end
    return res;
  endfunction

  assign clr_last_s = (clr_addr_r == LAST_ADDR);
  assign in_range_s = ({1'b0, addr_i} < DEPTH_W);
  assign rd_word_s  = in_range_s ? mem_r[addr_i] : WORD_ZERO;
  assign merged_s   = merge_lanes(rd_word_s, data_i, lane_en_i);

  // State register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= CLEAR;
      clr_addr_r <= ADDR_ZERO;
      ready_r    <= 1'b0;
      valid_r    <= 1'b0;
      data_r     <= WORD_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      clr_addr_r <= clr_addr_nxt_s;
      ready_r    <= ready_nxt_s;
      valid_r    <= valid_nxt_s;
      data_r     <= data_nxt_s;
    end
  end

  // Storage array; reset leaves contents alone, the clear sequence zeroes them.
  always_ff @(posedge clk_i) begin
    if (mem_we_s && !rst_i) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  // Next-state logic: sweep clr_addr in CLEAR, re-enter CLEAR on request.
  always_comb begin
    state_nxt_s    = state_r;
    clr_addr_nxt_s = clr_addr_r;
    case (state_r)
      CLEAR: begin
        clr_addr_nxt_s = clr_addr_r + ADDR_ONE;
        if (clr_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      IDLE: begin
        if (clear_i) begin
          state_nxt_s    = CLEAR;
          clr_addr_nxt_s = ADDR_ZERO;
        end else begin
          state_nxt_s    = IDLE;
          clr_addr_nxt_s = clr_addr_r;
        end
      end
      default: begin
        state_nxt_s    = CLEAR;
        clr_addr_nxt_s = ADDR_ZERO;
      end
    endcase
  end

  // Output and array-port logic; clear_i beats any access on the same edge.
  always_comb begin
    ready_nxt_s = ready_r;
    valid_nxt_s = 1'b0;
    data_nxt_s  = data_r;
    mem_we_s    = 1'b0;
    mem_addr_s  = clr_addr_r;
    mem_wdata_s = WORD_ZERO;
    case (state_r)
      CLEAR: begin
        mem_we_s    = 1'b1;
        mem_addr_s  = clr_addr_r;
        mem_wdata_s = WORD_ZERO;
        if (clr_last_s) begin
          ready_nxt_s = 1'b1;
        end else begin
          ready_nxt_s = 1'b0;
        end
      end
      IDLE: begin
        if (clear_i) begin
          ready_nxt_s = 1'b0;
        end else begin
          ready_nxt_s = 1'b1;
          if (WEn_i && in_range_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = addr_i;
            mem_wdata_s = merged_s;
          end else begin
            mem_we_s    = 1'b0;
          end
          if (REn_i) begin
            valid_nxt_s = 1'b1;
            if ((RDW_MODE != 0) && WEn_i && in_range_s) begin
              data_nxt_s = merged_s;
            end else begin
              data_nxt_s = rd_word_s;
            end
          end else begin
            valid_nxt_s = 1'b0;
            data_nxt_s  = data_r;
          end
        end
      end
      default: begin
        ready_nxt_s = 1'b0;
      end
    endcase
  end

  assign ready_o = ready_r;
  assign valid_o = valid_r;
  assign data_o  = data_r;

endmodule

// File: tb/tb_word_bank.sv
// Directed bench for word_bank: two instances share stimulus, one with old-data
// read-during-write and DEPTH=16, the other with new-data merge and DEPTH=12.
module tb_word_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic        wen = 1'b0;
  logic [1:0]  lanes = 2'b00;
  logic [15:0] data = 16'h0000;
  logic        ren = 1'b0;

  logic        ready_a, valid_a, ready_b, valid_b;
  logic [15:0] data_a, data_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  word_bank #(.BUSWIDTH(16), .LANEWIDTH(8), .DEPTH(16), .ADDRWIDTH(4), .RDW_MODE(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .ready_o(ready_a), .addr_i(addr),
    .WEn_i(wen), .lane_en_i(lanes), .data_i(data), .REn_i(ren), .data_o(data_a), .valid_o(valid_a)
  );

  word_bank #(.BUSWIDTH(16), .LANEWIDTH(8), .DEPTH(12), .ADDRWIDTH(4), .RDW_MODE(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .ready_o(ready_b), .addr_i(addr),
    .WEn_i(wen), .lane_en_i(lanes), .data_i(data), .REn_i(ren), .data_o(data_b), .valid_o(valid_b)
  );

  typedef struct {
    logic        wen;
    logic        ren;
    logic [1:0]  lanes;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        valid;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wen = 1'b0; ren = 1'b0; clear = 1'b0; lanes = 2'b00; data = 16'h0000; addr = 4'd0;
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < 16; a++) begin
      idle_inputs(); ren = 1'b1; addr = 4'(a);
      tick();
      check({name, "_valid_a"}, 16'(valid_a), 16'h0001);
      check({name, "_data_a"}, data_a, 16'h0000);
      check({name, "_valid_b"}, 16'(valid_b), 16'h0001);
      check({name, "_data_b"}, data_b, 16'h0000);
    end
    idle_inputs();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b11, 4'd3,  16'hABCD, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 2'b01, 4'd3,  16'h1234, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 4'd3,  16'h0000, 1'b1, 16'hAB34, 16'hAB34};
    vecs[3]  = '{1'b1, 1'b0, 2'b11, 4'd5,  16'h0011, 1'b0, 16'hAB34, 16'hAB34};
    vecs[4]  = '{1'b1, 1'b1, 2'b11, 4'd5,  16'h0022, 1'b1, 16'h0011, 16'h0022};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 4'd5,  16'h0000, 1'b1, 16'h0022, 16'h0022};
    vecs[6]  = '{1'b1, 1'b1, 2'b10, 4'd5,  16'h9900, 1'b1, 16'h0022, 16'h9922};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 4'd5,  16'h0000, 1'b1, 16'h9922, 16'h9922};
    vecs[8]  = '{1'b1, 1'b1, 2'b00, 4'd6,  16'hFFFF, 1'b1, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 4'd6,  16'h0000, 1'b1, 16'h0000, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 2'b11, 4'd13, 16'h0077, 1'b0, 16'h0000, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 2'b00, 4'd13, 16'h0000, 1'b1, 16'h0077, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 2'b00, 4'd5,  16'h0000, 1'b1, 16'h9922, 16'h9922};
    vecs[13] = '{1'b1, 1'b0, 2'b11, 4'd4,  16'h1111, 1'b0, 16'h9922, 16'h9922};
    vecs[14] = '{1'b0, 1'b1, 2'b00, 4'd4,  16'h0000, 1'b1, 16'h1111, 16'h1111};
    vecs[15] = '{1'b0, 1'b1, 2'b00, 4'd11, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    // vecs[8] writes addr 6 with no lanes while reading addr 6 itself (still zero)

    // Reset: outputs cleared, ready low until the sweep finishes
    idle_inputs();
    rst = 1'b1;
    tick();
    check("rst_ready_a", 16'(ready_a), 16'h0000);
    check("rst_valid_a", 16'(valid_a), 16'h0000);
    check("rst_data_a", data_a, 16'h0000);
    check("rst_ready_b", 16'(ready_b), 16'h0000);
    check("rst_valid_b", 16'(valid_b), 16'h0000);
    rst = 1'b0;
    ren = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("boot_ready_a_%0d", i), 16'(ready_a), 16'(i >= 16));
      check($sformatf("boot_valid_a_%0d", i), 16'(valid_a), 16'h0000);
      check($sformatf("boot_ready_b_%0d", i), 16'(ready_b), 16'(i >= 12));
      check($sformatf("boot_valid_b_%0d", i), 16'(valid_b), 16'(i >= 13));
    end
    read_all_zero("boot_read");
    tick();
    check("pulse_valid_a", 16'(valid_a), 16'h0000);
    check("pulse_valid_b", 16'(valid_b), 16'h0000);

    // Table-driven lane writes, read-during-write and out-of-range accesses
    for (int v = 0; v < 16; v++) begin
      wen = vecs[v].wen; ren = vecs[v].ren; lanes = vecs[v].lanes;
      addr = vecs[v].addr; data = vecs[v].data;
      tick();
      check($sformatf("vec%0d_valid_a", v), 16'(valid_a), 16'(vecs[v].valid));
      check($sformatf("vec%0d_data_a", v), data_a, vecs[v].exp_a);
      check($sformatf("vec%0d_valid_b", v), 16'(valid_b), 16'(vecs[v].valid));
      check($sformatf("vec%0d_data_b", v), data_b, vecs[v].exp_b);
    end
    idle_inputs();

    // Clear request: fill with ones, then clear together with a write to addr 0
    for (int a = 0; a < 16; a++) begin
      wen = 1'b1; lanes = 2'b11; addr = 4'(a); data = 16'hFFFF;
      tick();
    end
    idle_inputs();
    clear = 1'b1; wen = 1'b1; lanes = 2'b11; addr = 4'd0; data = 16'h0055;
    tick();
    check("clr_ready_a", 16'(ready_a), 16'h0000);
    check("clr_ready_b", 16'(ready_b), 16'h0000);
    idle_inputs();
    ren = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("clr_ready_a_%0d", i), 16'(ready_a), 16'(i >= 16));
      check($sformatf("clr_valid_a_%0d", i), 16'(valid_a), 16'h0000);
      check($sformatf("clr_ready_b_%0d", i), 16'(ready_b), 16'(i >= 12));
      check($sformatf("clr_valid_b_%0d", i), 16'(valid_b), 16'(i >= 13));
    end
    read_all_zero("clr_read");

    // Reset mid-clear: load a nonzero data_o first so its reset is observable
    wen = 1'b1; ren = 1'b1; lanes = 2'b11; addr = 4'd2; data = 16'hBEEF;
    tick();
    check("rdw2_data_a", data_a, 16'h0000);
    check("rdw2_data_b", data_b, 16'hBEEF);
    idle_inputs(); ren = 1'b1; addr = 4'd2;
    tick();
    check("rd2_data_a", data_a, 16'hBEEF);
    check("rd2_data_b", data_b, 16'hBEEF);
    idle_inputs(); clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1; clear = 1'b1;
    tick();
    check("mid_rst_ready_a", 16'(ready_a), 16'h0000);
    check("mid_rst_valid_a", 16'(valid_a), 16'h0000);
    check("mid_rst_data_a", data_a, 16'h0000);
    check("mid_rst_data_b", data_b, 16'h0000);
    rst = 1'b0; clear = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("mid_ready_a_%0d", i), 16'(ready_a), 16'(i >= 16));
      check($sformatf("mid_ready_b_%0d", i), 16'(ready_b), 16'(i >= 12));
    end
    ren = 1'b1; addr = 4'd2;
    tick();
    check("post_rd2_valid_a", 16'(valid_a), 16'h0001);
    check("post_rd2_data_a", data_a, 16'h0000);
    check("post_rd2_data_b", data_b, 16'h0000);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_bank.md
# word_bank

Parametrised, clocked successor to the single combinational word: a bank of DEPTH words, each BUSWIDTH bits, with per-lane write enables, a registered 1-cycle read port, and a hardware clear sequencer that zeroes every word after reset or on request. It sits between the address decoder and the datapath as the RAM core of the memory subsystem. It replaces arrays of individually instantiated words wherever a clocked, resettable store is needed.

## Interface
- BUSWIDTH, 8: bits per word.
- LANEWIDTH, 8: bits per write lane. BUSWIDTH must be an integer multiple of LANEWIDTH. LANES = BUSWIDTH/LANEWIDTH.
- DEPTH, 16: number of words, 2..2^ADDRWIDTH.
- ADDRWIDTH, 4: address bits.
- RDW_MODE, 0: read-during-write to the same address. 0 = old data; 1 = new data, merged per lane.

- clk_i, input, 1: single clock; all state updates on the rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- clear_i, input, 1: request a full clear of the bank (single-cycle pulse is sufficient).
- ready_o, output, 1: high when accesses are accepted.
- addr_i, input, ADDRWIDTH: word address shared by read and write.
- WEn_i, input, 1: write enable.
- lane_en_i, input, LANES: per-lane write mask; lane j covers data bits [j*LANEWIDTH +: LANEWIDTH].
- data_i, input, BUSWIDTH: write data.
- REn_i, input, 1: read enable.
- data_o, output, BUSWIDTH: registered read data.
- valid_o, output, 1: data_o carries the result of a read.

## Operation
- FSM has two states, CLEAR and IDLE. A clear counter clr_addr is ADDRWIDTH bits wide.
- Reset (rst_i high at an edge):
  - state <= CLEAR, clr_addr <= 0.
  - ready_o <= 0, valid_o <= 0, data_o <= 0.
  - Array contents are not touched by reset itself.
- CLEAR:
  - Each edge writes all-zero to word clr_addr, then clr_addr increments.
  - On the edge that clears word DEPTH-1: state <= IDLE, ready_o <= 1.
  - WEn_i, REn_i and clear_i are ignored; valid_o stays 0.
- IDLE, accesses with ready_o = 1:
  - Write: WEn_i high updates only the lanes of word addr_i whose lane_en_i bit is 1. lane_en_i = 0 means no change.
  - Read: REn_i high loads data_o with word addr_i and sets valid_o = 1 for exactly one cycle. Otherwise valid_o <= 0 and data_o holds its last value.
  - Simultaneous WEn_i and REn_i to the same address:
    - RDW_MODE 0: data_o = pre-write word.
    - RDW_MODE 1: enabled lanes come from data_i, other lanes from the stored word.
  - Simultaneous access to different addresses: both take effect independently.
- Out-of-range address (addr_i >= DEPTH): writes are dropped; reads return 0 with valid_o = 1.
- clear_i in IDLE:
  - state <= CLEAR, clr_addr <= 0, ready_o <= 0.
  - Any WEn_i or REn_i on the same edge is dropped; clear has priority.
- rst_i high mid-CLEAR or mid-access restarts the clear from word 0. rst_i has priority over clear_i.

## Timing
- Read latency is 1 cycle: REn_i sampled at edge k drives data_o and valid_o from edge k until edge k+1.
- Write latency is 0 cycles: a write sampled at edge k is visible to a read sampled at edge k+1.
- Back-to-back reads and writes are accepted every cycle in IDLE.
- Clear duration is exactly DEPTH cycles.
  - If rst_i is last high at edge 0, ready_o rises at edge DEPTH.
  - If clear_i is sampled at edge k, ready_o falls at edge k and rises at edge k+DEPTH.
- ready_o, valid_o and data_o are all registered; there are no combinational input-to-output paths.

## Test plan
- Reset release, DEPTH=16: ready_o = 0 for 16 cycles and rises at edge 16. Reads of all 16 addresses then return 0x00 with valid_o pulsing 1 cycle each.
- BUSWIDTH=16, LANEWIDTH=8:
  - Write 0xABCD to addr 3 with lane_en_i = 2'b11, then write 0x1234 with lane_en_i = 2'b01.
  - A subsequent read of addr 3 returns 0xAB34 one cycle after REn_i.
- Read-during-write:
  - Addr 5 holds 0x11. Write 0x22 and read addr 5 on the same edge.
  - RDW_MODE 0 gives data_o = 0x11; RDW_MODE 1 gives data_o = 0x22. A following read returns 0x22 in both modes.
- Clear request:
  - Fill all words with 0xFF, then pulse clear_i together with WEn_i to addr 0 (data 0x55). The write is dropped and ready_o = 0 for 16 cycles.
  - REn_i asserted during clear gives valid_o = 0.
  - After ready_o rises, all words read 0x00.
- Reset mid-clear: assert rst_i at clear cycle 7. ready_o stays 0, and ready_o rises exactly 16 cycles after rst_i is released.
- DEPTH=12, ADDRWIDTH=4: a write of 0x77 to addr 13 is dropped. A read of addr 13 returns 0x00 with valid_o = 1. Words 0..11 are unchanged.
